// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// responder states and the store byte-enable helper.
package dmem_pkg;

   localparam int DMEM_DEPTH = 1024;
   localparam int AW         = $clog2(DMEM_DEPTH);

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Byte lanes touched by a store of the given size at the given byte offset.
   function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B:    byte_en = 4'b0001 << off;
         F3_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
         F3_W:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the memory-access stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
   logic        i_read_en;
   logic        i_write_en;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        i_hold;
   logic        o_read_vd;
   logic [31:0] o_rdata;
   logic        o_misalign;
   logic        o_busy;

   modport master (
      output i_read_en, i_write_en, i_funct3, i_addr, i_wdata, i_hold,
      input  o_read_vd, o_rdata, o_misalign, o_busy
   );

   modport slave (
      input  i_read_en, i_write_en, i_funct3, i_addr, i_wdata, i_hold,
      output o_read_vd, o_rdata, o_misalign, o_busy
   );
endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword of a memory word, extends it according
// to the access size, and flags accesses that break natural alignment.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the byte lane addressed by the low offset bits
   always_comb begin
      w_byte = 8'd0;
      case (i_off)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = 8'd0;
      endcase
   end

   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   // Extend the selected lane; reserved size codes produce zero and never misalign
   always_comb begin
      o_data     = 32'd0;
      o_misalign = 1'b0;
      case (i_funct3)
         F3_B:  o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU: o_data = {24'd0, w_byte};
         F3_H: begin
            o_data     = {{16{w_half[15]}}, w_half};
            o_misalign = i_off[0];
         end
         F3_HU: begin
            o_data     = {16'd0, w_half};
            o_misalign = i_off[0];
         end
         F3_W: begin
            o_data     = i_word;
            o_misalign = (i_off != 2'b00);
         end
         default: begin
            o_data     = 32'd0;
            o_misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised SRAM serving M-stage loads after a
// fixed number of wait states, and single-cycle byte-enabled stores.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = DMEM_DEPTH,
   parameter int WAIT_CYCLES = 2
)
(
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);

   localparam int         IW        = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e        r_state;
   state_e        w_next_state;
   logic [3:0]    r_count;
   logic [3:0]    w_next_count;
   logic [IW-1:0] r_idx;
   logic [1:0]    r_off;
   logic [2:0]    r_funct3;
   logic          r_read_vd;
   logic [31:0]   r_rdata;
   logic [31:0]   r_mem [DEPTH];

   logic [IW-1:0] w_req_idx;
   logic [IW-1:0] w_ld_idx;
   logic [1:0]    w_ld_off;
   logic [2:0]    w_ld_funct3;
   logic [31:0]   w_word;
   logic [31:0]   w_ld_data;
   logic          w_ld_mis;
   logic          w_req_mis;
   logic [31:0]   w_unused_req_data;
   logic          w_unused_addr;
   logic          w_store;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_lanes;

   assign w_req_idx     = bus.i_addr[IW+1:2];
   assign w_unused_addr = ^bus.i_addr[31:IW+2];

   // In IDLE the response may be formed in the request cycle itself (no wait
   // states), so read through the live request; afterwards use the capture.
   assign w_ld_idx    = (r_state == IDLE) ? w_req_idx        : r_idx;
   assign w_ld_off    = (r_state == IDLE) ? bus.i_addr[1:0]  : r_off;
   assign w_ld_funct3 = (r_state == IDLE) ? bus.i_funct3     : r_funct3;
   assign w_word      = r_mem[w_ld_idx];

   dmem_load_align u_load_align (
      .i_word     (w_word),
      .i_off      (w_ld_off),
      .i_funct3   (w_ld_funct3),
      .o_data     (w_ld_data),
      .o_misalign (w_ld_mis)
   );

   // Alignment of the live request drives the misalign flag and store gating.
   dmem_load_align u_req_align (
      .i_word     (32'd0),
      .i_off      (bus.i_addr[1:0]),
      .i_funct3   (bus.i_funct3),
      .o_data     (w_unused_req_data),
      .o_misalign (w_req_mis)
   );

   assign w_store = (r_state == IDLE) && bus.i_write_en && !bus.i_read_en && !w_req_mis;
   assign w_be    = w_store ? byte_en(bus.i_funct3, bus.i_addr[1:0]) : 4'b0000;

   // Replicate right-aligned store data across every lane it could land in
   always_comb begin
      w_wdata_lanes = bus.i_wdata;
      case (bus.i_funct3)
         F3_B:    w_wdata_lanes = {4{bus.i_wdata[7:0]}};
         F3_H:    w_wdata_lanes = {2{bus.i_wdata[15:0]}};
         default: w_wdata_lanes = bus.i_wdata;
      endcase
   end

   // Next-state and wait counter for the load sequencer
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      case (r_state)
         IDLE: begin
            if (bus.i_read_en) begin
               w_next_count = WAIT_INIT;
               w_next_state = (WAIT_INIT != 4'd0) ? WAIT : RESP;
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT: begin
            w_next_count = r_count - 4'd1;
            if (r_count <= 4'd1) begin
               w_next_state = RESP;
            end else begin
               w_next_state = WAIT;
            end
         end
         RESP: begin
            if (bus.i_hold) begin
               w_next_state = RESP;
            end else begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
            w_next_count = 4'd0;
         end
      endcase
   end

   // Sequencer state, request capture and registered response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_count   <= 4'd0;
         r_idx     <= '0;
         r_off     <= 2'd0;
         r_funct3  <= 3'd0;
         r_read_vd <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_state   <= w_next_state;
         r_count   <= w_next_count;
         r_read_vd <= (w_next_state == RESP);
         if ((r_state == IDLE) && bus.i_read_en) begin
            r_idx    <= w_req_idx;
            r_off    <= bus.i_addr[1:0];
            r_funct3 <= bus.i_funct3;
         end
         if ((w_next_state == RESP) && (r_state != RESP)) begin
            r_rdata <= w_ld_mis ? 32'd0 : w_ld_data;
         end
      end
   end

   // Byte-enabled store into the array; contents survive reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_be[k]) begin
            r_mem[w_req_idx][8*k +: 8] <= w_wdata_lanes[8*k +: 8];
         end
      end
   end

   assign bus.o_read_vd  = r_read_vd;
   assign bus.o_rdata    = r_rdata;
   assign bus.o_busy     = (r_state != IDLE);
   assign bus.o_misalign = rst && (bus.i_read_en || bus.i_write_en) && w_req_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-addressed reference memory
// predicts every load response and the cycle it must appear in; a monitor
// process pops and compares each cycle the DUT shows read-valid.
module tb_dmem_responder;

   localparam int WC = 2;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   int          cyc;
   int          checks;
   int          errors;
   exp_t        q[$];
   logic [7:0]  mb [4096];

   dmem_responder_if bus_if();

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic ref_mis(input logic [31:0] a, input logic [2:0] f3);
      if (f3 == 3'd1 || f3 == 3'd5) return a[0];
      if (f3 == 3'd2) return (a[1:0] != 2'd0);
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
      int b;
      b = int'(a[11:0]);
      if (ref_mis(a, f3)) return 32'd0;
      case (f3)
         3'd0:    return int'(byte'(mb[b]));
         3'd4:    return {24'd0, mb[b]};
         3'd1:    return int'(shortint'({mb[b+1], mb[b]}));
         3'd5:    return {16'd0, mb[b+1], mb[b]};
         3'd2:    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
         default: return 32'd0;
      endcase
   endfunction

   function automatic void ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
      int b;
      b = int'(a[11:0]);
      if (ref_mis(a, f3)) return;
      case (f3)
         3'd0: mb[b] = wd[7:0];
         3'd1: begin mb[b] = wd[7:0]; mb[b+1] = wd[15:8]; end
         3'd2: begin
            mb[b] = wd[7:0]; mb[b+1] = wd[15:8]; mb[b+2] = wd[23:16]; mb[b+3] = wd[31:24];
         end
         default: ;
      endcase
   endfunction

   task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      bus_if.i_read_en  = re;
      bus_if.i_write_en = we;
      bus_if.i_funct3   = f3;
      bus_if.i_addr     = a;
      bus_if.i_wdata    = wd;
      bus_if.i_hold     = 1'b0;
   endtask

   // Issue a load in the next cycle, predict its response, stall h cycles in RESP.
   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int h, input logic wr_too);
      exp_t e;
      int   k;
      int   n;
      bit   got;
      @(posedge clk); #1;
      drive(1'b1, wr_too, f3, a, $urandom);
      e.data = ref_load(a, f3);
      for (int i = 0; i <= h; i++) begin
         e.cyc = cyc + WC + 1 + i;
         q.push_back(e);
      end
      @(negedge clk);
      chk("load_misalign", {31'd0, bus_if.o_misalign}, {31'd0, ref_mis(a, f3)});
      chk("load_busy_idle", {31'd0, bus_if.o_busy}, 32'd0);
      k = 0; n = 0; got = 1'b0;
      while (n < 64) begin
         if (bus_if.o_read_vd === 1'b1) begin
            if (k < h) begin
               bus_if.i_hold = 1'b1;
               k++;
            end else begin
               bus_if.i_hold = 1'b0;
               got = 1'b1;
               break;
            end
         end
         @(negedge clk);
         n++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL load_timeout actual=no_response required=response addr=%h", a);
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd, input int ncyc);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, f3, a, wd);
      ref_store(a, f3, wd);
      @(negedge clk);
      chk("store_misalign", {31'd0, bus_if.o_misalign}, {31'd0, ref_mis(a, f3)});
      repeat (ncyc - 1) @(negedge clk);
   endtask

   task automatic do_idle();
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd2, $urandom, $urandom);
      @(negedge clk);
      chk("idle_misalign", {31'd0, bus_if.o_misalign}, 32'd0);
      chk("idle_busy", {31'd0, bus_if.o_busy}, 32'd0);
   endtask

   // Load, then drop the read and attempt a store during WAIT and RESP.
   task automatic load_then_busy_store(input logic [31:0] a);
      exp_t e;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd2, a, 32'd0);
      e.data = ref_load(a, 3'd2);
      e.cyc  = cyc + WC + 1;
      q.push_back(e);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd2, a, ~ref_load(a, 3'd2));
      @(negedge clk);
      chk("busy_in_wait", {31'd0, bus_if.o_busy}, 32'd1);
      repeat (WC) @(negedge clk);
   endtask

   // Scoreboard monitor: every read-valid cycle must match the next prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.o_read_vd === 1'b1) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read_vd actual=1 required=0 rdata=%h cycle=%0d", bus_if.o_rdata, cyc);
            end else begin
               e = q.pop_front();
               chk("rdata", bus_if.o_rdata, e.data);
               chk("rvd_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic [2:0]  f3tab [8];
      int          op;
      checks = 0;
      errors = 0;
      f3tab[0] = 3'd0; f3tab[1] = 3'd1; f3tab[2] = 3'd2; f3tab[3] = 3'd4;
      f3tab[4] = 3'd5; f3tab[5] = 3'd3; f3tab[6] = 3'd6; f3tab[7] = 3'd7;
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("reset_read_vd", {31'd0, bus_if.o_read_vd}, 32'd0);
      chk("reset_rdata", bus_if.o_rdata, 32'd0);
      chk("reset_busy", {31'd0, bus_if.o_busy}, 32'd0);
      chk("reset_misalign", {31'd0, bus_if.o_misalign}, 32'd0);
      rst = 1'b1;

      // Fill a 16-word pool (with random upper address bits to exercise wrap)
      for (int w = 0; w < 16; w++) begin
         do_store(($urandom & 32'hFFFFF000) | 32'(w * 4), 3'd2, $urandom, 1);
      end

      do_store(32'h0000_0010, 3'd2, 32'hDEADBEEF, 1);
      do_load(32'h0000_0010, 3'd2, 0, 1'b0);

      // Reset in the first WAIT cycle aborts the load
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_if.i_read_en = 1'b0;
      #2;
      chk("midwait_busy", {31'd0, bus_if.o_busy}, 32'd0);
      chk("midwait_read_vd", {31'd0, bus_if.o_read_vd}, 32'd0);
      chk("midwait_rdata", bus_if.o_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      do_idle();
      do_load(32'h0000_0010, 3'd2, 0, 1'b0);

      do_load(32'h0000_0013, 3'd0, 0, 1'b0);
      do_load(32'h0000_0013, 3'd4, 0, 1'b0);
      do_load(32'h0000_0012, 3'd1, 0, 1'b0);
      do_load(32'h0000_0012, 3'd5, 0, 1'b0);
      do_load(32'h0000_0010, 3'd0, 0, 1'b0);
      do_store(32'h0000_0011, 3'd0, 32'h0000_0055, 1);
      do_load(32'h0000_0010, 3'd2, 0, 1'b0);

      load_then_busy_store(32'h0000_0010);
      do_load(32'h0000_0010, 3'd2, 0, 1'b1);

      // Held response, then a back-to-back load of the same address
      do_load(32'h0000_0010, 3'd2, 3, 1'b0);
      do_load(32'h0000_0010, 3'd2, 0, 1'b0);

      do_load(32'h0000_0012, 3'd2, 0, 1'b0);
      do_store(32'h0000_0013, 3'd1, 32'h0000_1234, 2);
      do_load(32'h0000_0010, 3'd2, 0, 1'b0);

      for (int i = 0; i < 160; i++) begin
         op = $urandom_range(0, 9);
         a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
         if (op <= 4) begin
            f3 = f3tab[$urandom_range(0, 7)];
            do_load(a, f3, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         end else if (op <= 7) begin
            f3 = 3'($urandom_range(0, 2));
            do_store(a, f3, $urandom, $urandom_range(1, 2));
         end else begin
            do_idle();
         end
      end

      do_idle();
      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
